// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD stage behind the ALU: sign plus three decimal digits
// via shift-add-3, one bit per clock, with registered digits for the display mux.
module result_bcd_converter #(
    parameter bit          AUTO  = 1'b1,
    parameter int unsigned NBITS = 8
) (
    input  logic       CLK100MHZ,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] VALUE,
    input  logic [1:0] MODE,
    output logic       BUSY,
    output logic       DONE,
    output logic       VALID,
    output logic       NEG,
    output logic [3:0] BCD2,
    output logic [3:0] BCD1,
    output logic [3:0] BCD0
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ACC_W = 12;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_val, w_val_nxt;
    logic [1:0]         r_mode, w_mode_nxt;
    logic               r_sign, w_sign_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic [ACC_W-1:0]   r_acc, w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_neg, w_neg_nxt;
    logic [ACC_W-1:0]   r_bcd, w_bcd_nxt;

    logic               w_trigger;
    logic               w_sign;
    logic [7:0]         w_ext;
    logic [7:0]         w_mag;
    logic [ACC_W-1:0]   w_acc_adj;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? 4'(n + 4'd3) : n;
    endfunction

    // Sign, width extension and magnitude of the incoming ALU result
    always_comb begin
        w_sign = 1'b0;
        w_ext  = VALUE;
        case (MODE)
            2'b01: begin
                w_sign = VALUE[4];
                w_ext  = {{3{VALUE[4]}}, VALUE[4:0]};
            end
            2'b10:   w_sign = VALUE[7];
            2'b11:   w_ext  = {4'b0000, VALUE[3:0]};
            default: w_sign = 1'b0;
        endcase
        w_mag = w_sign ? 8'(~w_ext + 8'd1) : w_ext;
    end

    assign w_trigger = START || (AUTO && ({VALUE, MODE} != {r_val, r_mode}));
    assign w_acc_adj = {add3(r_acc[11:8]), add3(r_acc[7:4]), add3(r_acc[3:0])};

    // Next-state and datapath updates
    always_comb begin
        w_state_nxt = r_state;
        w_val_nxt   = r_val;
        w_mode_nxt  = r_mode;
        w_sign_nxt  = r_sign;
        w_shift_nxt = r_shift;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_valid_nxt = r_valid;
        w_neg_nxt   = r_neg;
        w_bcd_nxt   = r_bcd;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_val_nxt   = VALUE;
                    w_mode_nxt  = MODE;
                    w_sign_nxt  = w_sign;
                    w_shift_nxt = w_mag;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                {w_acc_nxt, w_shift_nxt} = {w_acc_adj[ACC_W-2:0], r_shift, 1'b0};
                w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
                if (r_cnt == LAST_BIT) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                w_bcd_nxt   = r_acc;
                w_neg_nxt   = r_sign;
                w_done_nxt  = 1'b1;
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            r_state <= IDLE;
            r_val   <= '0;
            r_mode  <= '0;
            r_sign  <= 1'b0;
            r_shift <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_neg   <= 1'b0;
            r_bcd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_val   <= w_val_nxt;
            r_mode  <= w_mode_nxt;
            r_sign  <= w_sign_nxt;
            r_shift <= w_shift_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_valid <= w_valid_nxt;
            r_neg   <= w_neg_nxt;
            r_bcd   <= w_bcd_nxt;
        end
    end

    assign BUSY  = r_busy;
    assign DONE  = r_done;
    assign VALID = r_valid;
    assign NEG   = r_neg;
    assign BCD2  = r_bcd[11:8];
    assign BCD1  = r_bcd[7:4];
    assign BCD0  = r_bcd[3:0];

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed bench: one converter with AUTO=0 driven by START, one with AUTO=1
// driven by VALUE changes; results packed as 0x{NEG}{BCD2}{BCD1}{BCD0}.
module tb_result_bcd_converter;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_start, b_start;
    logic [7:0] a_val, b_val;
    logic [1:0] a_mode, b_mode;
    logic       a_busy, a_done, a_valid, a_neg;
    logic       b_busy, b_done, b_valid, b_neg;
    logic [3:0] a_bcd2, a_bcd1, a_bcd0;
    logic [3:0] b_bcd2, b_bcd1, b_bcd0;
    logic [15:0] a_res, b_res;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    assign a_res = {3'b000, a_neg, a_bcd2, a_bcd1, a_bcd0};
    assign b_res = {3'b000, b_neg, b_bcd2, b_bcd1, b_bcd0};

    result_bcd_converter #(.AUTO(1'b0), .NBITS(8)) u_dut_a (
        .CLK100MHZ(clk), .RESET(reset), .START(a_start), .VALUE(a_val), .MODE(a_mode),
        .BUSY(a_busy), .DONE(a_done), .VALID(a_valid), .NEG(a_neg),
        .BCD2(a_bcd2), .BCD1(a_bcd1), .BCD0(a_bcd0)
    );

    result_bcd_converter #(.AUTO(1'b1), .NBITS(8)) u_dut_b (
        .CLK100MHZ(clk), .RESET(reset), .START(b_start), .VALUE(b_val), .MODE(b_mode),
        .BUSY(b_busy), .DONE(b_done), .VALID(b_valid), .NEG(b_neg),
        .BCD2(b_bcd2), .BCD1(b_bcd1), .BCD0(b_bcd0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // START-driven conversion on the AUTO=0 instance with full latency checks
    task automatic conv_a(input string tag, input logic [7:0] v, input logic [1:0] m,
                          input logic [15:0] exp);
        logic [15:0] old;
        old     = a_res;
        a_val   = v;
        a_mode  = m;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check({tag, "_busy_k"}, 32'(a_busy), 32'd1);
        repeat (8) tick();
        check({tag, "_busy_k8"}, 32'(a_busy), 32'd1);
        check({tag, "_done_k8"}, 32'(a_done), 32'd0);
        check({tag, "_hold_k8"}, 32'(a_res), 32'(old));
        tick();
        check({tag, "_done_k9"}, 32'(a_done), 32'd1);
        check({tag, "_busy_k9"}, 32'(a_busy), 32'd0);
        check({tag, "_valid"}, 32'(a_valid), 32'd1);
        check({tag, "_res"}, 32'(a_res), 32'(exp));
        tick();
        check({tag, "_done_k10"}, 32'(a_done), 32'd0);
    endtask

    initial begin
        int n_a, n_b;
        reset   = 1'b1;
        a_start = 1'b0;  b_start = 1'b0;
        a_val   = 8'h00; b_val   = 8'h00;
        a_mode  = 2'b00; b_mode  = 2'b00;
        repeat (3) tick();
        check("rst_a_out", 32'({a_busy, a_done, a_valid, a_res}), 32'd0);
        check("rst_b_out", 32'({b_busy, b_done, b_valid, b_res}), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_a_busy", 32'(a_busy), 32'd0);
        check("idle_b_busy", 32'(b_busy), 32'd0);

        conv_a("u8_ff",  8'hFF, 2'b00, 16'h0255);
        conv_a("s5_m7",  8'h19, 2'b01, 16'h1007);
        conv_a("s5_p14", 8'h0E, 2'b01, 16'h0014);
        conv_a("s8_80",  8'h80, 2'b10, 16'h1128);
        conv_a("s8_c4",  8'hC4, 2'b10, 16'h1060);
        conv_a("s8_31",  8'h31, 2'b10, 16'h0049);
        conv_a("u4_ab",  8'hAB, 2'b11, 16'h0011);
        conv_a("same",   8'hAB, 2'b11, 16'h0011);
        conv_a("s8_zero", 8'h00, 2'b10, 16'h0000);
        conv_a("s8_31b", 8'h31, 2'b10, 16'h0049);

        // START during BUSY is ignored; digits hold until k+9
        a_val = 8'h07; a_mode = 2'b00; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (2) tick();
        a_start = 1'b1; a_val = 8'h99;
        tick();
        a_start = 1'b0;
        repeat (5) tick();
        check("busy_start_hold", 32'(a_res), 32'h0049);
        check("busy_start_busy", 32'(a_busy), 32'd1);
        tick();
        check("busy_start_done", 32'(a_done), 32'd1);
        check("busy_start_res", 32'(a_res), 32'h0007);
        n_a = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (a_done) n_a++;
        end
        check("busy_start_no_more_done", 32'(n_a), 32'd0);
        check("busy_start_idle", 32'(a_busy), 32'd0);

        // AUTO: value change mid-conversion reconverts right after DONE
        b_val = 8'h05;
        tick();
        check("auto_busy_k", 32'(b_busy), 32'd1);
        repeat (3) tick();
        b_val = 8'h63;
        repeat (5) tick();
        check("auto_done_k8", 32'(b_done), 32'd0);
        tick();
        check("auto_done1", 32'(b_done), 32'd1);
        check("auto_res1", 32'(b_res), 32'h0005);
        tick();
        check("auto_done1_end", 32'(b_done), 32'd0);
        check("auto_rebusy", 32'(b_busy), 32'd1);
        repeat (8) tick();
        check("auto_done2_early", 32'(b_done), 32'd0);
        tick();
        check("auto_done2", 32'(b_done), 32'd1);
        check("auto_res2", 32'(b_res), 32'h0099);
        n_b = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (b_done) n_b++;
        end
        check("auto_steady", 32'(n_b), 32'd0);

        // RESET mid-conversion aborts and clears everything
        a_val = 8'hFF; a_mode = 2'b00; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_a", 32'({a_busy, a_done, a_valid, a_res}), 32'd0);
        check("rst_mid_b", 32'({b_busy, b_done, b_valid, b_res}), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_after_a_busy", 32'(a_busy), 32'd0);
        check("rst_after_b_retrig", 32'(b_busy), 32'd1);
        check("rst_after_b_valid", 32'(b_valid), 32'd0);
        n_a = 0;
        n_b = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (a_done) n_a++;
            if (b_done) n_b++;
        end
        check("rst_a_no_done", 32'(n_a), 32'd0);
        check("rst_b_one_done", 32'(n_b), 32'd1);
        check("rst_b_res", 32'(b_res), 32'h0099);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
